// File: rtl/risc_datapath.sv
// risc_datapath: IR, PC, accumulator and ALU for the 8-bit accumulator RISC.
// All state is updated on the rising clock edge and cleared by a synchronous,
// active-high reset. Control strobes arrive from control_unit; the opcode and
// zero flag are returned to it.
module risc_datapath #(
  parameter int OPCODE_WIDTH = 3,
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sel,
  input  logic                    ld_ir,
  input  logic                    inc_pc,
  input  logic                    ld_pc,
  input  logic                    ld_ac,
  input  logic                    data_e,
  input  logic                    halt,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic                    mem_wdata_oe,
  output logic [OPCODE_WIDTH-1:0] opcode,
  output logic                    is_zero,
  output logic [ADDR_WIDTH-1:0]   pc,
  output logic [DATA_WIDTH-1:0]   ac
);

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_t;

  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] ac_q, ac_d;
  logic [DATA_WIDTH-1:0] aluResult;
  logic [ADDR_WIDTH-1:0] irOperand;
  opcode_t               irOpcode;

  assign irOpcode  = opcode_t'(ir_q[DATA_WIDTH-1 -: OPCODE_WIDTH]);
  assign irOperand = ir_q[ADDR_WIDTH-1:0];

  // IR captures the memory word on ld_ir and holds otherwise.
  always_comb begin
    ir_d = ir_q;
    if (ld_ir) begin
      ir_d = mem_rdata;
    end
  end

  // PC priority: halt freezes it, then a jump load beats an increment.
  // The load uses the IR operand as it stands before any same-edge IR load.
  always_comb begin
    pc_d = pc_q;
    if (halt) begin
      pc_d = pc_q;
    end else if (ld_pc) begin
      pc_d = irOperand;
    end else if (inc_pc) begin
      pc_d = pc_q + ADDR_WIDTH'(1);
    end
  end

  // ALU works on the registered opcode, so a same-edge IR load does not
  // change the operation applied to the accumulator.
  always_comb begin
    aluResult = ac_q;
    case (irOpcode)
      OP_ADD:  aluResult = ac_q + mem_rdata;
      OP_AND:  aluResult = ac_q & mem_rdata;
      OP_XOR:  aluResult = ac_q ^ mem_rdata;
      OP_LDA:  aluResult = mem_rdata;
      default: aluResult = ac_q;
    endcase
  end

  // Accumulator takes the ALU result on ld_ac and holds otherwise.
  always_comb begin
    ac_d = ac_q;
    if (ld_ac) begin
      ac_d = aluResult;
    end
  end

  // State registers; reset overrides every load and increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q <= '0;
      pc_q <= '0;
      ac_q <= '0;
    end else begin
      ir_q <= ir_d;
      pc_q <= pc_d;
      ac_q <= ac_d;
    end
  end

  assign mem_addr     = sel ? pc_q : irOperand;
  assign mem_wdata    = ac_q;
  assign mem_wdata_oe = data_e;
  assign opcode       = ir_q[DATA_WIDTH-1 -: OPCODE_WIDTH];
  assign is_zero      = (ac_q == '0);
  assign pc           = pc_q;
  assign ac           = ac_q;

endmodule
